// File: rtl/pad_supply_seq.sv
// Pad-ring supply sequencer: IO supply first, then core, settle, then release pads.
// Optional sticky fault on supply loss in ACTIVE: define PAD_SEQ_FAULT_LATCH_EN.
module pad_supply_seq #(
    parameter int unsigned DBNC_CYC   = 16,
    parameter int unsigned SETTLE_CYC = 64
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       DVDD_OK,
    input  logic       VDD_OK,
    input  logic       CLR_FAULT,
    output logic       ISO_N,
    output logic       OE_EN,
    output logic       POR_N,
    output logic [2:0] STATE,
    output logic       FAULT
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_WAIT_DVDD = 3'd1,
        ST_WAIT_VDD  = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    localparam logic [7:0] DBNC_MAX    = 8'(DBNC_CYC);
    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYC - 1);

    state_e     state_q, state_d;
    logic [1:0] meta_q, sync_q;
    logic [7:0] dbnc_q [2];
    logic [7:0] dbnc_d [2];
    logic [1:0] acc;
    logic [9:0] settle_q, settle_d;
    logic       iso_q, oe_q, por_q;
    logic       both_ok;

    // Bit 0 tracks DVDD_OK, bit 1 tracks VDD_OK.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {VDD_OK, DVDD_OK};
            sync_q <= meta_q;
        end
    end

    // Accepted flag is qualified by the live sync bit so a low cycle drops it immediately.
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            dbnc_d[i] = '0;
            if (sync_q[i]) begin
                dbnc_d[i] = (dbnc_q[i] == DBNC_MAX) ? dbnc_q[i] : dbnc_q[i] + 8'd1;
            end
            acc[i] = sync_q[i] && (dbnc_q[i] == DBNC_MAX);
        end
    end

    assign both_ok = acc[0] & acc[1];

    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            ST_OFF:       state_d = ST_WAIT_DVDD;
            ST_WAIT_DVDD: if (acc[0]) state_d = ST_WAIT_VDD;
            ST_WAIT_VDD: begin
                if (!acc[0])     state_d = ST_WAIT_DVDD;
                else if (acc[1]) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!both_ok) begin
                    state_d = ST_WAIT_DVDD;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    settle_d = settle_q + 10'd1;
                end
            end
            ST_ACTIVE: begin
                if (!both_ok) begin
`ifdef PAD_SEQ_FAULT_LATCH_EN
                    state_d = ST_FAULT;
`else
                    state_d = ST_WAIT_DVDD;
`endif
                end
            end
`ifdef PAD_SEQ_FAULT_LATCH_EN
            ST_FAULT: if (CLR_FAULT) state_d = ST_WAIT_DVDD;
`endif
            default:      state_d = ST_OFF;
        endcase
    end

    // Enables are decoded from the next state so all three change on the same edge.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_OFF;
            settle_q  <= '0;
            dbnc_q[0] <= '0;
            dbnc_q[1] <= '0;
            iso_q     <= 1'b0;
            oe_q      <= 1'b0;
            por_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            dbnc_q[0] <= dbnc_d[0];
            dbnc_q[1] <= dbnc_d[1];
            iso_q     <= (state_d == ST_SETTLE) || (state_d == ST_ACTIVE);
            oe_q      <= (state_d == ST_ACTIVE);
            por_q     <= (state_d == ST_ACTIVE);
        end
    end

`ifdef PAD_SEQ_FAULT_LATCH_EN
    logic fault_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) fault_q <= 1'b0;
        else     fault_q <= (state_d == ST_FAULT);
    end

    assign FAULT = fault_q;
`else
    logic unused_clr_fault;

    assign unused_clr_fault = CLR_FAULT;
    assign FAULT            = 1'b0;
`endif

    assign ISO_N = iso_q;
    assign OE_EN = oe_q;
    assign POR_N = por_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_pad_supply_seq.sv
// Directed bench for pad_supply_seq with DBNC_CYC=4, SETTLE_CYC=8.
// Follows PAD_SEQ_FAULT_LATCH_EN if defined for the build.
module tb_pad_supply_seq;

    logic       CLK;
    logic       RN;
    logic       DVDD_OK;
    logic       VDD_OK;
    logic       CLR_FAULT;
    logic       ISO_N;
    logic       OE_EN;
    logic       POR_N;
    logic [2:0] STATE;
    logic       FAULT;

    int unsigned checks;
    int unsigned failures;

    pad_supply_seq #(
        .DBNC_CYC  (4),
        .SETTLE_CYC(8)
    ) dut (
        .CLK      (CLK),
        .RN       (RN),
        .DVDD_OK  (DVDD_OK),
        .VDD_OK   (VDD_OK),
        .CLR_FAULT(CLR_FAULT),
        .ISO_N    (ISO_N),
        .OE_EN    (OE_EN),
        .POR_N    (POR_N),
        .STATE    (STATE),
        .FAULT    (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge, sample 1ns later, and check the pad-safety invariant.
    task automatic step();
        @(posedge CLK);
        #1;
        check("oe_without_iso", {31'b0, OE_EN & ~ISO_N}, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_iso"},   {31'b0, ISO_N}, 32'd0);
        check({tag, "_oe"},    {31'b0, OE_EN}, 32'd0);
        check({tag, "_por"},   {31'b0, POR_N}, 32'd0);
        check({tag, "_fault"}, {31'b0, FAULT}, 32'd0);
        check({tag, "_state"}, {29'b0, STATE}, 32'd0);
    endtask

    // Reset held for a few cycles, released mid-cycle.
    task automatic do_reset(input logic dv, input logic vd);
        RN        = 1'b0;
        DVDD_OK   = dv;
        VDD_OK    = vd;
        CLR_FAULT = 1'b0;
        repeat (3) step();
        check_idle("rst");
        #2;
        RN = 1'b1;
    endtask

    // Edge k counted from the first edge that captures the last needed input rise
    // (or the first edge after reset with both supplies already high):
    // 2 sync + 4 debounce -> WAIT_VDD at k=7, SETTLE at k=8, ACTIVE at k=16.
    task automatic run_seq(input string tag);
        logic [2:0] es;
        for (int k = 1; k <= 16; k++) begin
            step();
            es = (k < 7) ? 3'd1 : (k < 8) ? 3'd2 : (k < 16) ? 3'd3 : 3'd4;
            check({tag, "_state"}, {29'b0, STATE}, {29'b0, es});
            check({tag, "_iso"},   {31'b0, ISO_N}, {31'b0, (k >= 8)});
            check({tag, "_oe"},    {31'b0, OE_EN}, {31'b0, (k >= 16)});
            check({tag, "_por"},   {31'b0, POR_N}, {31'b0, (k >= 16)});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RN        = 1'b0;
        DVDD_OK   = 1'b0;
        VDD_OK    = 1'b0;
        CLR_FAULT = 1'b0;
        #1;
        check_idle("por0");

        // Both supplies good before reset release.
        do_reset(1'b1, 1'b1);
        run_seq("both");

        // CLR_FAULT while ACTIVE has no effect.
        CLR_FAULT = 1'b1;
        step();
        CLR_FAULT = 1'b0;
        check("clr_act_state", {29'b0, STATE}, 32'd4);
        check("clr_act_oe",    {31'b0, OE_EN}, 32'd1);
        check("clr_act_fault", {31'b0, FAULT}, 32'd0);

        // One-cycle VDD_OK dropout while ACTIVE.
        VDD_OK = 1'b0;
        step();
        check("drop_e1_state", {29'b0, STATE}, 32'd4);
        VDD_OK = 1'b1;
        step();
        check("drop_e2_state", {29'b0, STATE}, 32'd4);
        check("drop_e2_oe",    {31'b0, OE_EN}, 32'd1);
        step();
        check("drop_e3_iso", {31'b0, ISO_N}, 32'd0);
        check("drop_e3_oe",  {31'b0, OE_EN}, 32'd0);
        check("drop_e3_por", {31'b0, POR_N}, 32'd0);
`ifdef PAD_SEQ_FAULT_LATCH_EN
        check("drop_e3_state", {29'b0, STATE}, 32'd5);
        check("drop_e3_fault", {31'b0, FAULT}, 32'd1);
        repeat (10) step();
        check("flt_hold_state", {29'b0, STATE}, 32'd5);
        check("flt_hold_fault", {31'b0, FAULT}, 32'd1);
        check("flt_hold_iso",   {31'b0, ISO_N}, 32'd0);
        CLR_FAULT = 1'b1;
        step();
        CLR_FAULT = 1'b0;
        check("flt_clr_state", {29'b0, STATE}, 32'd1);
        check("flt_clr_fault", {31'b0, FAULT}, 32'd0);
        step();
        check("flt_re_wvdd", {29'b0, STATE}, 32'd2);
        for (int k = 2; k <= 10; k++) begin
            step();
            check("flt_re_state", {29'b0, STATE}, (k < 10) ? 32'd3 : 32'd4);
            check("flt_re_iso",   {31'b0, ISO_N}, 32'd1);
            check("flt_re_oe",    {31'b0, OE_EN}, {31'b0, (k == 10)});
        end
`else
        check("drop_e3_state", {29'b0, STATE}, 32'd1);
        check("drop_e3_fault", {31'b0, FAULT}, 32'd0);
        for (int k = 4; k <= 16; k++) begin
            step();
            check("reseq_state", {29'b0, STATE},
                  (k < 8) ? 32'd2 : (k < 16) ? 32'd3 : 32'd4);
            check("reseq_iso",   {31'b0, ISO_N}, {31'b0, (k >= 8)});
            check("reseq_oe",    {31'b0, OE_EN}, {31'b0, (k >= 16)});
            check("reseq_fault", {31'b0, FAULT}, 32'd0);
        end
`endif

        // Asynchronous reset pulse while in SETTLE, entirely between edges.
        do_reset(1'b1, 1'b1);
        repeat (10) step();
        check("pre_arst_state", {29'b0, STATE}, 32'd3);
        check("pre_arst_iso",   {31'b0, ISO_N}, 32'd1);
        #2;
        RN = 1'b0;
        #1;
        check_idle("arst");
        #2;
        RN = 1'b1;
        run_seq("arst_rel");

        // VDD_OK first; DVDD_OK 50 cycles later.
        do_reset(1'b0, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            step();
            check("vdd1st_state", {29'b0, STATE}, 32'd1);
            check("vdd1st_iso",   {31'b0, ISO_N}, 32'd0);
        end
        DVDD_OK = 1'b1;
        run_seq("vdd1st");

        // DVDD_OK glitch: high 3, low 1, then high; debounce restarts.
        do_reset(1'b0, 1'b1);
        repeat (5) step();
        DVDD_OK = 1'b1;
        repeat (3) step();
        DVDD_OK = 1'b0;
        step();
        DVDD_OK = 1'b1;
        run_seq("glitch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pad_supply_seq.md
PAD_SUPPLY_SEQ -- requirements
Module: pad_supply_seq

Interface
REQ-001 SHALL have parameter DBNC_CYC, default 16, meaning consecutive synchronized-high cycles needed to accept a supply-good input (legal 1..255).
REQ-002 SHALL have parameter SETTLE_CYC, default 64, meaning cycles between both supplies accepted and release of pad outputs (legal 1..1023).
REQ-003 SHALL have port CLK  input  1  sequencer clock, rising-edge active.
REQ-004 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port DVDD_OK  input  1  IO-ring supply comparator output, asynchronous to CLK.
REQ-006 SHALL have port VDD_OK  input  1  core supply comparator output, asynchronous to CLK.
REQ-007 SHALL have port CLR_FAULT  input  1  single-cycle fault-clear request.
REQ-008 SHALL have port ISO_N  output  1  low = pad-ring inputs isolated from core.
REQ-009 SHALL have port OE_EN  output  1  high = pad output drivers may be enabled.
REQ-010 SHALL have port POR_N  output  1  active-low core reset derived from sequence.
REQ-011 SHALL have port STATE  output  3  current sequencer state encoding.
REQ-012 SHALL have port FAULT  output  1  high = supply lost while ACTIVE.

Function
REQ-013 SHALL synchronize DVDD_OK and VDD_OK through two CLK flops each before any use; latency from input edge to sync value SHALL be 2 cycles.
REQ-014 SHALL debounce each synchronized input with a counter: accepted-good after DBNC_CYC consecutive high cycles; any low cycle clears the counter and the accepted flag in the same cycle.
REQ-015 SHALL implement states OFF=0, WAIT_DVDD=1, WAIT_VDD=2, SETTLE=3, ACTIVE=4, FAULT=5; codes 6,7 SHALL go to OFF on the next cycle.
REQ-016 OFF -> WAIT_DVDD unconditionally on the first cycle after reset release.
REQ-017 WAIT_DVDD -> WAIT_VDD when DVDD accepted; IO supply SHALL be required first.
REQ-018 WAIT_VDD -> SETTLE when VDD accepted and DVDD still accepted; DVDD loss in WAIT_VDD -> WAIT_DVDD.
REQ-019 SETTLE SHALL count SETTLE_CYC cycles, then -> ACTIVE; loss of either accepted flag during SETTLE -> WAIT_DVDD with counter cleared.
REQ-020 ACTIVE: loss of either accepted flag SHALL leave ACTIVE on the next cycle (target per REQ-029/030).
REQ-021 Outputs SHALL be registered: ISO_N=1 in SETTLE and ACTIVE; OE_EN=1 only in ACTIVE; POR_N=1 only in ACTIVE; all else 0.
REQ-022 On supply loss from ACTIVE, OE_EN and POR_N SHALL fall in the same cycle as ISO_N; no cycle with OE_EN=1 and ISO_N=0 SHALL ever occur.
REQ-023 STATE SHALL equal the registered state code, no added latency.
REQ-024 Simultaneous loss of both supplies SHALL be treated as a single loss event.
REQ-025 CLR_FAULT outside FAULT state SHALL be ignored.

Reset
REQ-026 RN low SHALL asynchronously force state OFF, synchronizers, debounce and settle counters to 0.
REQ-027 During and after reset, until sequenced: ISO_N=0, OE_EN=0, POR_N=0, FAULT=0, STATE=0.
REQ-028 RN asserted mid-sequence (any state) SHALL produce the REQ-027 values immediately, independent of CLK.

Configuration
REQ-029 With PAD_SEQ_FAULT_LATCH_EN defined: supply loss in ACTIVE -> FAULT; FAULT SHALL set FAULT=1 (sticky), hold all enables low, and go to WAIT_DVDD only on CLR_FAULT=1, clearing FAULT the same edge.
REQ-030 Without PAD_SEQ_FAULT_LATCH_EN: supply loss in ACTIVE -> WAIT_DVDD directly; FAULT SHALL be tied 0, state 5 unreachable, CLR_FAULT unused.

Verification
REQ-031 DBNC_CYC=4, SETTLE_CYC=8; RN release, both OK high -> OE_EN/POR_N rise exactly at fixed cycle count 2+4+1(+VDD acceptance)+8 after reset; ISO_N rises 8 cycles earlier.
REQ-032 VDD_OK high first, DVDD_OK high 50 cycles later -> STATE passes 1,2,3,4 in order; ISO_N stays 0 until DVDD accepted and VDD confirmed.
REQ-033 DVDD_OK glitch: high 3 cycles, low 1, high -> acceptance delayed; counter restarts, accepted 4 cycles after final rise+sync.
REQ-034 In ACTIVE, drop VDD_OK for 1 cycle -> with macro: STATE=5, FAULT=1, enables 0 until CLR_FAULT pulse; without: STATE=1, re-sequence to ACTIVE, FAULT=0.
REQ-035 RN pulsed low during SETTLE between clock edges -> ISO_N falls without clock edge; after release sequence restarts from OFF.
REQ-036 Assertion over all tests: never OE_EN=1 while ISO_N=0; CLR_FAULT in ACTIVE changes nothing.
